// File: rtl/aes_pkg.sv
// aes_pkg: shared AES opcode and word types
package aes_pkg;
  typedef enum logic [2:0] {
    NOOP       = 3'd0,
    AESDEC     = 3'd1,
    AESDECLAST = 3'd2,
    AESIMC     = 3'd3,
    AESDECFULL = 3'd4
  } opcode;
  typedef logic [31:0] aes_32;
endpackage

// File: rtl/aes_dec_ctrl_if.sv
// aes_dec_ctrl_if: request and datapath-control bundle of the AES decryption controller
interface aes_dec_ctrl_if;
  import aes_pkg::*;
  logic  start_i;
  opcode opcode_i;
  logic  busy_o;
  logic  first_rnd_o;
  logic  inv_mix_o;
  logic  final_rnd_o;
  logic  imc_only_o;
  logic  key_sel_o;
  logic  en_rnd_o;
  logic  en_key_o;
  logic  key_sub_o;
  logic  inv_key_o;
  logic  plain_ready_o;
  logic  key_ready_o;
  aes_32 r_con_ctrl_o;
  modport master (
    output start_i, opcode_i,
    input  busy_o, first_rnd_o, inv_mix_o, final_rnd_o, imc_only_o, key_sel_o,
           en_rnd_o, en_key_o, key_sub_o, inv_key_o, plain_ready_o, key_ready_o, r_con_ctrl_o
  );
  modport slave (
    input  start_i, opcode_i,
    output busy_o, first_rnd_o, inv_mix_o, final_rnd_o, imc_only_o, key_sel_o,
           en_rnd_o, en_key_o, key_sub_o, inv_key_o, plain_ready_o, key_ready_o, r_con_ctrl_o
  );
endinterface

// File: rtl/aes_dec_ctrl.sv
// aes_dec_ctrl: sequences inverse AES rounds, IMC key transform and full 10-round decryption
module aes_dec_ctrl
  import aes_pkg::*;
(
  input logic            clk,
  input logic            nrst,
  aes_dec_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SBOX, ROUND, FINISH} state_t;
  state_t      state_q, state_d;
  opcode       op_q, op_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [7:0]  rcon_q, rcon_d;
  assign bus.busy_o       = state_q != IDLE;
  assign bus.r_con_ctrl_o = {rcon_q, 24'h0};
  // state, latched opcode, round counter and rcon registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= NOOP;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h36;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
    end
  end
  // next-state and datapath control decode
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    rnd_d             = rnd_q;
    rcon_d            = rcon_q;
    bus.en_rnd_o      = 1'b1;
    bus.en_key_o      = 1'b1;
    bus.first_rnd_o   = 1'b0;
    bus.inv_mix_o     = 1'b0;
    bus.final_rnd_o   = 1'b0;
    bus.imc_only_o    = 1'b0;
    bus.key_sel_o     = 1'b0;
    bus.key_sub_o     = 1'b0;
    bus.inv_key_o     = 1'b0;
    bus.plain_ready_o = 1'b0;
    bus.key_ready_o   = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) begin
        case (bus.opcode_i)
          AESDEC, AESDECLAST: begin
            bus.en_key_o = 1'b0;
            state_d      = SBOX;
            op_d         = bus.opcode_i;
          end
          AESIMC: begin
            bus.en_rnd_o = 1'b0;
            state_d      = ROUND;
            op_d         = bus.opcode_i;
          end
          AESDECFULL: begin
            bus.first_rnd_o = 1'b1;
            bus.key_sub_o   = 1'b1;
            state_d         = SBOX;
            op_d            = bus.opcode_i;
            rnd_d           = 4'd0;
            rcon_d          = 8'h36;
          end
          default: ;
        endcase
      end
      SBOX: begin
        state_d = ROUND;
        if (op_q == AESDECFULL) begin
          bus.inv_key_o = 1'b1;
          bus.key_sel_o = 1'b1;
          rnd_d         = rnd_q + 4'd1;
        end
      end
      ROUND: begin
        state_d = FINISH;
        case (op_q)
          AESDEC:     bus.inv_mix_o   = 1'b1;
          AESDECLAST: bus.final_rnd_o = 1'b1;
          AESIMC:     bus.imc_only_o  = 1'b1;
          AESDECFULL: begin
            bus.key_sel_o = 1'b1;
            rcon_d = rcon_q == 8'h36 ? 8'h1b : rcon_q == 8'h1b ? 8'h80 : rcon_q >> 1;
            if (rnd_q == 4'd10) bus.final_rnd_o = 1'b1;
            else begin
              bus.inv_mix_o = 1'b1;
              bus.key_sub_o = 1'b1;
              state_d       = SBOX;
            end
          end
          default: ;
        endcase
      end
      FINISH: begin
        bus.key_ready_o   = op_q == AESIMC;
        bus.plain_ready_o = op_q != AESIMC;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb_aes_dec_ctrl: table, hand-sequence and randomized checks against a per-operation cycle model
module tb_aes_dec_ctrl;
  import aes_pkg::*;
  typedef struct packed {
    logic busy, first, inv_mix, fin, imc, key_sel, en_rnd, en_key, key_sub, inv_key, plain, key_rdy;
    logic [31:0] rcon;
  } out_t;
  typedef struct {
    logic       s;
    logic [2:0] op;
    logic [3:0] c0;
    int         len;
    logic [1:0] rdy;
  } vec_t;
  logic clk = 1'b0, nrst = 1'b0;
  int checks = 0, errors = 0;
  out_t q[$];
  logic [7:0] rcon_m = 8'h36;
  logic [7:0] rtab [0:10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
  vec_t tbl [8];
  aes_dec_ctrl_if bus ();
  aes_dec_ctrl dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  function automatic out_t idle_out();
    out_t o = '0;
    o.en_rnd = 1'b1;
    o.en_key = 1'b1;
    o.rcon   = {rcon_m, 24'h0};
    return o;
  endfunction
  function automatic out_t got_out();
    return '{bus.busy_o, bus.first_rnd_o, bus.inv_mix_o, bus.final_rnd_o, bus.imc_only_o, bus.key_sel_o,
             bus.en_rnd_o, bus.en_key_o, bus.key_sub_o, bus.inv_key_o, bus.plain_ready_o, bus.key_ready_o,
             bus.r_con_ctrl_o};
  endfunction
  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, g, e);
    end
  endtask
  task automatic gen(input logic [2:0] op);
    out_t o = idle_out();
    out_t b;
    if (op == 3'd1 || op == 3'd2) begin
      o.en_key = 1'b0; q.push_back(o);
      b = idle_out(); b.busy = 1'b1;
      q.push_back(b);
      o = b; o.inv_mix = op == 3'd1; o.fin = op == 3'd2; q.push_back(o);
      o = b; o.plain = 1'b1; q.push_back(o);
    end else if (op == 3'd3) begin
      o.en_rnd = 1'b0; q.push_back(o);
      b = idle_out(); b.busy = 1'b1;
      o = b; o.imc = 1'b1; q.push_back(o);
      o = b; o.key_rdy = 1'b1; q.push_back(o);
    end else begin
      o.first = 1'b1; o.key_sub = 1'b1; q.push_back(o);
      for (int k = 1; k <= 10; k++) begin
        b = idle_out(); b.busy = 1'b1; b.rcon = {rtab[k-1], 24'h0};
        o = b; o.inv_key = 1'b1; o.key_sel = 1'b1; q.push_back(o);
        o = b; o.key_sel = 1'b1; o.inv_mix = k < 10; o.key_sub = k < 10; o.fin = k == 10; q.push_back(o);
      end
      o = idle_out(); o.busy = 1'b1; o.plain = 1'b1; o.rcon = 32'h0; q.push_back(o);
      rcon_m = 8'h00;
    end
  endtask
  task automatic step(input logic s, input logic [2:0] op, input string nm, output out_t g);
    out_t e;
    @(negedge clk);
    bus.start_i  = s;
    bus.opcode_i = opcode'(op);
    #1;
    if (q.size() == 0 && s && op >= 3'd1 && op <= 3'd4) gen(op);
    e = q.size() != 0 ? q.pop_front() : idle_out();
    g = got_out();
    chk(nm, 64'(g), 64'(e));
  endtask
  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    bus.start_i = 1'b0;
    #1;
    q.delete();
    rcon_m = 8'h36;
    chk("reset_outputs", 64'(got_out()), 64'(idle_out()));
    @(negedge clk);
    nrst = 1'b1;
  endtask
  initial begin
    out_t g;
    int n;
    logic sk, sp;
    bus.start_i  = 1'b0;
    bus.opcode_i = NOOP;
    tbl[0] = '{1'b1, 3'd1, 4'b1000, 3,  2'b01};
    tbl[1] = '{1'b1, 3'd2, 4'b1000, 3,  2'b01};
    tbl[2] = '{1'b1, 3'd3, 4'b0100, 2,  2'b10};
    tbl[3] = '{1'b1, 3'd4, 4'b1111, 21, 2'b01};
    tbl[4] = '{1'b1, 3'd0, 4'b1100, 0,  2'b00};
    tbl[5] = '{1'b1, 3'd7, 4'b1100, 0,  2'b00};
    tbl[6] = '{1'b1, 3'd5, 4'b1100, 0,  2'b00};
    tbl[7] = '{1'b0, 3'd1, 4'b1100, 0,  2'b00};
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].op, "tbl_model", g);
      chk($sformatf("tbl%0d_c0", i), 64'({g.en_rnd, g.en_key, g.first, g.key_sub}), 64'(tbl[i].c0));
      n = 0; sk = 0; sp = 0;
      for (int c = 0; c < 40; c++) begin
        step(1'b0, 3'd0, "tbl_model", g);
        if (!g.busy) break;
        n++; sk |= g.key_rdy; sp |= g.plain;
      end
      chk($sformatf("tbl%0d_len", i), 64'(n), 64'(tbl[i].len));
      chk($sformatf("tbl%0d_rdy", i), 64'({sk, sp}), 64'(tbl[i].rdy));
    end
    step(1'b1, 3'd4, "full_rst", g);
    for (int c = 1; c <= 8; c++) step(1'b0, 3'd0, "full_rst", g);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    g = got_out();
    chk("rst_mid_busy", 64'(g.busy), 64'(0));
    chk("rst_mid_rcon", 64'(g.rcon), 64'(32'h3600_0000));
    chk("rst_mid_plain", 64'(g.plain), 64'(0));
    q.delete();
    rcon_m = 8'h36;
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 3'd1, "dec_after_rst", g);
    for (int c = 1; c <= 3; c++) step(1'b0, 3'd0, "dec_after_rst", g);
    chk("dec_after_rst_c3", 64'(g.plain), 64'(1));
    step(1'b1, 3'd4, "full_ign", g);
    for (int c = 1; c <= 21; c++) begin
      step(c == 5, 3'd1, "full_ign", g);
      if (c == 20) chk("full_c20", 64'({g.fin, g.rcon[31:24]}), 64'({1'b1, 8'h01}));
    end
    chk("full_c21_plain", 64'(g.plain), 64'(1));
    step(1'b0, 3'd0, "full_done", g);
    chk("full_done_busy", 64'(g.busy), 64'(0));
    step(1'b1, 3'd2, "last_imc", g);
    for (int c = 1; c <= 3; c++) begin
      step(1'b1, 3'd3, "last_imc", g);
      if (c == 2) chk("last_c2_final", 64'(g.fin), 64'(1));
    end
    step(1'b1, 3'd3, "imc_accept", g);
    chk("imc_accept_busy", 64'(g.busy), 64'(0));
    step(1'b0, 3'd0, "imc_c1", g);
    step(1'b0, 3'd0, "imc_c2", g);
    chk("imc_c2_rdy", 64'({g.key_rdy, g.plain}), 64'(2'b10));
    for (int i = 0; i < 400; i++) step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), "rand", g);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_dec_ctrl.md
# aes_dec_ctrl

Control FSM for the AES decryption datapath. It sequences single inverse rounds (AESDEC, AESDECLAST), the InvMixColumns key transform (AESIMC), and a full 10-round decryption (AESDECFULL) driven by an inverse key schedule. It sits between the instruction front-end and the aes_dec datapath / inverse key_gen, and mirrors the encryption-side control.

## Interface
- No parameters; opcode encoding comes from aes_pkg::opcode (NOOP, AESDEC, AESDECLAST, AESIMC, AESDECFULL; any other value is treated as NOOP).
- clk  in  1  clock
- nrst  in  1  reset; one clock; reset is asynchronous and active-low
- start_i  in  1  request strobe, sampled in IDLE only
- opcode_i  in  aes_pkg::opcode  operation, valid with start_i
- busy_o  out  1  high whenever state != IDLE
- first_rnd_o  out  1  initial AddRoundKey only (DECFULL accept cycle)
- inv_mix_o  out  1  apply InvMixColumns in the current round
- final_rnd_o  out  1  last round (no InvMixColumns)
- imc_only_o  out  1  datapath passes key input through InvMixColumns only
- key_sel_o  out  1  1 = internal inverse-schedule key, 0 = external key
- en_rnd_o / en_key_o  out  1 each  pipeline enables for the state and key datapaths
- key_sub_o  out  1  key-path S-box request
- inv_key_o  out  1  step the inverse key schedule
- plain_ready_o / key_ready_o  out  1 each  one-cycle completion pulses
- r_con_ctrl_o  out  aes_pkg::aes_32  byte 3 = current rcon, bytes 0–2 = 0

## Operation
- States: IDLE, SBOX, ROUND, FINISH. Registers: state, op_q (latched on accept only), rnd_num (4 bits), and rcon (8 bits).
- Output defaults in every cycle: en_rnd_o = en_key_o = 1, all other 1-bit outputs = 0.
- IDLE, start_i=1:
  - AESDEC / AESDECLAST: en_key_o = 0, go to SBOX.
  - AESIMC: en_rnd_o = 0, go to ROUND.
  - AESDECFULL: first_rnd_o = 1, key_sel_o = 0, key_sub_o = 1, go to SBOX. Load rnd_num to 0 and rcon to 0x36. Input key = round-10 key.
  - NOOP / other: stay in IDLE, op_q unchanged.
- SBOX:
  - AESDEC / AESDECLAST: go to ROUND.
  - AESDECFULL: inv_key_o = 1, key_sel_o = 1, rnd_num += 1, go to ROUND.
- ROUND:
  - AESDEC: inv_mix_o = 1, go to FINISH.
  - AESDECLAST: final_rnd_o = 1, go to FINISH.
  - AESIMC: imc_only_o = 1, go to FINISH.
  - AESDECFULL: key_sel_o = 1, then update rcon: 0x36→0x1b, 0x1b→0x80, otherwise rcon >> 1.
    - If rnd_num == 10: final_rnd_o = 1, go to FINISH.
    - Otherwise: inv_mix_o = 1, key_sub_o = 1, go to SBOX.
- FINISH: key_ready_o = 1 if op_q == AESIMC, else plain_ready_o = 1. Go to IDLE.
- rcon sequence seen across DECFULL rounds 1..10: 36,1b,80,40,20,10,08,04,02,01. After the final update rcon = 0x00 and holds until the next DECFULL accept.
- start_i while busy_o = 1 is ignored. No queueing, and op_q is not overwritten.
- Any undefined state recovers to IDLE on the next clock.

## Timing
- Accept edge = the clk edge at which IDLE sees start_i=1. Cycles below are counted after that edge.
- AESDEC / AESDECLAST: SBOX c1, ROUND c2, FINISH c3 (plain_ready_o high in c3). Next accept possible at the end of c4 (IDLE).
- AESIMC: ROUND c1, FINISH c2 (key_ready_o high in c2).
- AESDECFULL: SBOX/ROUND alternate over c1–c20 (round k: SBOX c2k-1, ROUND c2k). FINISH is c21.
- Ready pulses are exactly one cycle wide. busy_o falls in the cycle after FINISH.
- Reset state (asynchronous, immediate): state = IDLE, op_q = NOOP, rnd_num = 0, rcon = 0x36, r_con_ctrl_o = {0x36,0,0,0} (byte 3 = 0x36). busy_o = 0, en_rnd_o = en_key_o = 1, all other outputs 0.
- Reset mid-operation aborts with no ready pulse. The first accept after release behaves as from power-up.
- All control outputs are combinational from state/op_q, plus opcode_i in IDLE. r_con_ctrl_o is registered.

## Test plan
- Reset during DECFULL round 5 → busy_o = 0 and r_con_ctrl_o byte 3 = 0x36 immediately. No plain_ready_o. A new AESDEC accept completes in c3.
- AESDEC accepted → en_key_o = 0 in the accept cycle. SBOX c1, ROUND c2 with inv_mix_o = 1, plain_ready_o in c3 only.
- AESDECLAST, then AESIMC back-to-back → final_rnd_o = 1 in c2 of the first op. The second op's start_i is held during busy and accepted only in IDLE. key_ready_o at its c2, plain_ready_o never for the IMC op.
- AESDECFULL → first_rnd_o at accept, rcon bytes per ROUND 36,1b,80,40,20,10,08,04,02,01. inv_mix_o = 1 in ROUND for rounds 1–9, final_rnd_o = 1 only in c20, plain_ready_o in c21, rnd_num = 10.
- start_i pulsed with AESDEC at c5 of a DECFULL → ignored. op_q stays DECFULL and the sequence is unchanged.
- NOOP and an illegal opcode with start_i in IDLE → state stays IDLE, busy_o = 0, no pulses.
